xor_arb: RTL and testbench
==========================

# xor_arb

Shared-XOR-unit controller: arbitrates between `N_REQ` requesters for one WIDTH-bit XOR datapath using round-robin fair scheduling. It sequences each accepted operation through a registered XOR stage and returns the result, tagged with the requester ID, on a single response channel with backpressure. It sits between requester blocks that need `a ^ b` and the single XOR resource, so the resource is never duplicated per requester.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; legal range 2..16.
- `WIDTH`, 8: operand and result width in bits.
- `ID_W`, $clog2(N_REQ): width of the requester ID.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input N_REQ: bit i means requester i presents an operation.
- `req_a` input N_REQ*WIDTH: operand A; slice i is `[i*WIDTH +: WIDTH]`.
- `req_b` input N_REQ*WIDTH: operand B; same slicing as `req_a`.
- `req_ready` output N_REQ: one-hot accept strobe to the granted requester.
- `rsp_valid` output 1: response is valid.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_id` output ID_W: index of the requester the response belongs to.
- `rsp_data` output WIDTH: `a ^ b` for the accepted operation.
- `rsp_parity` output 1: reduction XOR of `rsp_data`.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE:**
  - If any `req_valid` bit is set, pick a winner by round-robin, searching upward from `ptr` and wrapping at `N_REQ-1` to 0.
  - `req_ready[winner]` = 1, combinationally, in this state only.
  - On the clock edge, latch `a`, `b` and the winner ID, then go to EXEC.
  - If no `req_valid` bit is set, stay in IDLE.
- **EXEC:** register `rsp_data <= a ^ b` and `rsp_parity <= ^(a ^ b)`, then go to RESP.
- **RESP:**
  - Hold `rsp_valid` = 1 with `rsp_id` and `rsp_data` stable.
  - On `rsp_ready`: go to IDLE and set `ptr <= (winner == N_REQ-1) ? 0 : winner+1`.
  - With `rsp_ready` low: stay in RESP indefinitely, with outputs unchanged.
- Requester rules:
  - A requester must hold `req_valid`, `req_a` and `req_b` stable until it sees `req_ready`.
  - Dropping `req_valid` before the grant is allowed; that requester is simply not chosen.
- Simultaneous requests: exactly one grant per IDLE cycle; the others wait. Fairness: every requester is granted within `N_REQ` operations.
- Only one operation is ever in flight. No request is accepted while `busy` is high.
- Reset values (also applied on reset asserted mid-operation):
  - `state` = IDLE, `ptr` = 0.
  - `req_ready`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_parity` and `busy` are all 0.
  - An in-flight operation is discarded and no response is produced.

## Timing
- Accept handshake at edge T (IDLE, `req_valid[i] & req_ready[i]`).
- EXEC in cycle T+1. `rsp_valid` rises in cycle T+2.
- Handshake-to-response latency is 2 cycles.
- With `rsp_ready` tied to 1, RESP lasts 1 cycle and IDLE is re-entered at T+3.
- Peak throughput is therefore 1 operation per 3 cycles.
- `req_ready` depends on `state`, `ptr` and `req_valid` only. No combinational path from `rsp_ready` to `req_ready`.

## Configuration
- `XOR_ARB_FIXED_PRIO_EN` defined:
  - Requester 0 has absolute priority. If `req_valid[0]` = 1 in IDLE, it wins regardless of `ptr`.
  - The remaining requesters are arbitrated round-robin as above.
  - `ptr` updates only when a requester other than 0 is granted.
- Undefined: pure round-robin over all requesters.

## Structure
- Package `xor_arb_pkg` holds:
  - the state enum (`IDLE`, `EXEC`, `RESP`);
  - defaults for `N_REQ` and `WIDTH`;
  - the ID-width localparam.
- One sub-module, `rr_pick`. It takes the request vector and `ptr` and returns a one-hot grant plus the encoded index. It is purely combinational and parameterised by `N_REQ`.

## Test plan
- Single request: `req_valid`=0001, a=0xA5, b=0x0F, `rsp_ready`=1.
  - `req_ready`=0001 at T.
  - `rsp_valid` at T+2 with `rsp_data`=0xAA, `rsp_parity`=0, `rsp_id`=0.
- All four requesting continuously after reset, `rsp_ready`=1: grant order is 0,1,2,3,0. Each response carries the matching ID and XOR value.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP.
  - `rsp_valid` and `rsp_data` stay stable; `req_ready` stays 0000.
  - The next grant comes only after `rsp_ready`.
- Wrap-around: `ptr`=3, `req_valid`=1001 → requester 3 is granted, then requester 0.
- Reset mid-operation: assert `rst_n`=0 during EXEC.
  - All outputs go to 0 immediately.
  - After release, no response appears and the next grant starts from requester 0.
- With `XOR_ARB_FIXED_PRIO_EN` defined: `req_valid`=0111 held continuously → grant sequence 0,0,0. After `req_valid[0]` drops, grants are 1,2,1.

Source files
------------

// File: rtl/xor_arb_pkg.sv
// Shared types and defaults for the xor_arb shared-XOR controller.
package xor_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int ID_W_DEF  = $clog2(N_REQ_DEF);

  // ID width that never collapses to zero bits.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xor_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_pick
  import xor_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // k is the search distance from ptr; the first hit wins.
    for (int k = 0; k < N_REQ; k++) begin
      for (int c = 0; c < N_REQ; c++) begin
        if (!any && req[c] && (c == ((int'(ptr) + k) % N_REQ))) begin
          any    = 1'b1;
          gnt[c] = 1'b1;
          idx    = ID_W'(c);
        end
      end
    end
  end

endmodule

// File: rtl/xor_arb.sv
// Round-robin arbiter in front of one registered XOR unit; response tagged with requester ID.
// Define XOR_ARB_FIXED_PRIO_EN to give requester 0 absolute priority over the round-robin.
module xor_arb
  import xor_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_parity,
  output logic                   busy
);

  function automatic logic parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_nxt;
  logic [ID_W-1:0]   id_p0;
  logic [WIDTH-1:0]  a_p0, b_p0, a_sel, b_sel;
  logic [WIDTH-1:0]  data_p1;
  logic              parity_p1;

  logic [N_REQ-1:0]  rr_req, rr_gnt, win_gnt;
  logic [ID_W-1:0]   rr_idx, win_idx;
  logic              rr_any, win_any, accept, release_rsp, ptr_upd;

`ifdef XOR_ARB_FIXED_PRIO_EN
  // Requester 0 bypasses the rotation; the rest share the round-robin.
  assign rr_req  = {req_valid[N_REQ-1:1], 1'b0};
  assign win_any = req_valid[0] | rr_any;
  assign win_gnt = req_valid[0] ? N_REQ'(1) : rr_gnt;
  assign win_idx = req_valid[0] ? '0 : rr_idx;
  assign ptr_upd = (id_p0 != '0);
`else
  assign rr_req  = req_valid;
  assign win_any = rr_any;
  assign win_gnt = rr_gnt;
  assign win_idx = rr_idx;
  assign ptr_upd = 1'b1;
`endif

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req (rr_req),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      a_sel = a_sel | (req_a[i*WIDTH +: WIDTH] & {WIDTH{win_gnt[i]}});
      b_sel = b_sel | (req_b[i*WIDTH +: WIDTH] & {WIDTH{win_gnt[i]}});
    end
  end

  assign accept      = (state_q == IDLE) && win_any;
  assign release_rsp = (state_q == RESP) && rsp_ready;
  assign ptr_nxt     = (id_p0 == ID_W'(N_REQ - 1)) ? '0 : id_p0 + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_any)   state_d = EXEC;
      EXEC:                   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Stage p0: accept in IDLE, capture winner ID and operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      id_p0 <= '0;
    end else begin
      if (accept)                id_p0 <= win_idx;
      if (release_rsp && ptr_upd) ptr_q <= ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0 <= a_sel;
      b_p0 <= b_sel;
    end
  end

  // Stage p1: registered XOR result, held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1   <= '0;
      parity_p1 <= 1'b0;
    end else if (state_q == EXEC) begin
      data_p1   <= a_p0 ^ b_p0;
      parity_p1 <= parity(a_p0 ^ b_p0);
    end
  end

  always_comb begin
    req_ready  = ((state_q == IDLE) && rst_n) ? win_gnt : '0;
    rsp_valid  = (state_q == RESP);
    busy       = (state_q != IDLE);
    rsp_id     = id_p0;
    rsp_data   = data_p1;
    rsp_parity = parity_p1;
  end

endmodule

// File: tb/tb_xor_arb.sv
// Randomized and directed bench for xor_arb against a behavioural arbitration model.
module tb_xor_arb;

  localparam int N = 4;
  localparam int W = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_a, req_b;
  logic [N-1:0]    req_ready;
  logic            rsp_valid, rsp_ready, rsp_parity, busy;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_data;

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  logic [W-1:0] last_data;
  logic         last_par;
  int           w;

  xor_arb #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_parity (rsp_parity),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: scan requesters starting at the model pointer.
  function automatic int model_pick(input logic [N-1:0] v);
    logic [N-1:0] vv = v;
`ifdef XOR_ARB_FIXED_PRIO_EN
    if (vv[0]) return 0;
    vv[0] = 1'b0;
`endif
    for (int k = 0; k < N; k++)
      if (vv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      op_a[i] = W'($urandom);
      op_b[i] = W'($urandom);
    end
    drive_ops();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_ptr = 0;
  endtask

  // One full transaction from IDLE: grant, EXEC, RESP with `hold` stalled cycles.
  task automatic do_op(input logic [N-1:0] vld, input int hold, output int win);
    logic [W-1:0] exp_d;
    req_valid = vld;
    drive_ops();
    #1;
    win = model_pick(vld);
    chk("grant_onehot", 32'(req_ready), 32'(1 << win));
    chk("idle_busy", 32'(busy), 32'd0);
    exp_d = op_a[win] ^ op_b[win];
    @(posedge clk); #1;
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_ready", 32'(req_ready), 32'd0);
    chk("exec_valid", 32'(rsp_valid), 32'd0);
    op_a[win] = W'($urandom);
    op_b[win] = W'($urandom);
    drive_ops();
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(win));
    chk("rsp_data", 32'(rsp_data), 32'(exp_d));
    chk("rsp_parity", 32'(rsp_parity), 32'(^exp_d));
    last_data = rsp_data;
    last_par  = rsp_parity;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'(exp_d));
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_idle_valid", 32'(rsp_valid), 32'd0);
    chk("back_idle_busy", 32'(busy), 32'd0);
`ifdef XOR_ARB_FIXED_PRIO_EN
    if (win != 0) m_ptr = (win + 1) % N;
`else
    m_ptr = (win + 1) % N;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    #2;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    do_reset();

    // Idle with no requests
    repeat (3) @(posedge clk);
    #1 chk("idle_no_req", 32'(busy), 32'd0);

    // Single request from requester 0
    rand_ops();
    op_a[0] = 8'hA5;
    op_b[0] = 8'h0F;
    do_op(4'b0001, 0, w);
    chk("single_id", 32'(w), 32'd0);
    chk("single_data", 32'(last_data), 32'hAA);
    chk("single_par", 32'(last_par), 32'd0);

    // Reset during EXEC discards the operation
    rand_ops();
    req_valid = 4'b1111;
    @(posedge clk); #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_data", 32'(rsp_data), 32'd0);
    chk("mid_rst_id", 32'(rsp_id), 32'd0);
    chk("mid_rst_par", 32'(rsp_parity), 32'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_ptr = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // All four requesting continuously
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      do_op(4'b1111, 0, w);
`ifndef XOR_ARB_FIXED_PRIO_EN
      chk("rr_order", 32'(w), 32'(k % N));
`endif
    end

    // Wrap-around from requester 3 back to 0
    rand_ops();
    do_op(4'b0100, 0, w);
    do_op(4'b1001, 0, w);
`ifndef XOR_ARB_FIXED_PRIO_EN
    chk("wrap_first", 32'(w), 32'd3);
`endif
    do_op(4'b1001, 0, w);
    chk("wrap_second", 32'(w), 32'd0);

    // Backpressure for 5 cycles
    rand_ops();
    do_op(4'b1111, 5, w);

    // Random traffic with random stalls
    for (int n = 0; n < 40; n++) begin
      logic [N-1:0] v;
      v = N'($urandom_range(1, (1 << N) - 1));
      rand_ops();
      do_op(v, int'($urandom_range(0, 3)), w);
    end

`ifdef XOR_ARB_FIXED_PRIO_EN
    do_reset();
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      do_op(4'b0111, 0, w);
      chk("fixed_prio0", 32'(w), 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      do_op(4'b0110, 0, w);
      chk("fixed_rr", 32'(w), (k == 1) ? 32'd2 : 32'd1);
    end
`endif

    req_valid = '0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
